// File: rtl/calcn_engine.sv
// Multi-port calculator: per-port two-beat operand capture into a request FIFO,
// shared round-robin arithmetic and shift units, registered per-port responses.
module calcn_engine #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 2
) (
  input  logic                          c_clk,
  input  logic                          reset,
  input  logic [NUM_PORTS*4-1:0]        req_cmd_in,
  input  logic [NUM_PORTS*DATA_W-1:0]   req_data_in,
  output logic [NUM_PORTS*2-1:0]        out_resp,
  output logic [NUM_PORTS*DATA_W-1:0]   out_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int SW = $clog2(DATA_W);

  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_LSH = 4'd5;
  localparam logic [3:0] CMD_RSH = 4'd6;

  typedef enum logic {S_IDLE, S_OP2} cap_state_t;

  cap_state_t           cap_state [NUM_PORTS];
  logic [3:0]           cap_cmd   [NUM_PORTS];
  logic [DATA_W-1:0]    cap_op1   [NUM_PORTS];
  logic [3:0]           q_cmd     [NUM_PORTS][DEPTH];
  logic [DATA_W-1:0]    q_op1     [NUM_PORTS][DEPTH];
  logic [DATA_W-1:0]    q_op2     [NUM_PORTS][DEPTH];
  logic [PW-1:0]        rd_ptr    [NUM_PORTS];
  logic [PW-1:0]        wr_ptr    [NUM_PORTS];
  logic [CW-1:0]        count     [NUM_PORTS];
  logic [NUM_PORTS-1:0] err_pend;
  logic [IW-1:0]        rr_arith;
  logic [IW-1:0]        rr_shift;

  logic [3:0]           head_cmd  [NUM_PORTS];
  logic [DATA_W-1:0]    head_op1  [NUM_PORTS];
  logic [DATA_W-1:0]    head_op2  [NUM_PORTS];
  logic [DATA_W:0]      head_sum  [NUM_PORTS];
  logic [1:0]           res_code  [NUM_PORTS];
  logic [DATA_W-1:0]    res_data  [NUM_PORTS];
  logic [NUM_PORTS-1:0] want_arith, want_shift, head_invalid;
  logic [NUM_PORTS-1:0] grant_arith, grant_shift, pop, push, push_ok;

  // First requester at or after ptr, wrapping modulo NUM_PORTS.
  function automatic logic [NUM_PORTS-1:0] rr_pick(input logic [NUM_PORTS-1:0] want,
                                                   input logic [IW-1:0] ptr);
    logic [NUM_PORTS-1:0] gnt;
    logic                 found;
    logic [IW:0]          pos;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      pos = {1'b0, ptr} + (IW+1)'(i);
      if (pos >= (IW+1)'(NUM_PORTS)) pos = pos - (IW+1)'(NUM_PORTS);
      if (!found && want[pos[IW-1:0]]) begin
        gnt[pos[IW-1:0]] = 1'b1;
        found            = 1'b1;
      end
    end
    return gnt;
  endfunction

  always_comb begin
    want_arith   = '0;
    want_shift   = '0;
    head_invalid = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      head_cmd[p] = q_cmd[p][rd_ptr[p]];
      head_op1[p] = q_op1[p][rd_ptr[p]];
      head_op2[p] = q_op2[p][rd_ptr[p]];
      head_sum[p] = {1'b0, head_op1[p]} + {1'b0, head_op2[p]};
      res_code[p] = 2'd2;
      res_data[p] = '0;
      case (head_cmd[p])
        CMD_ADD: begin
          want_arith[p] = (count[p] != '0);
          if (!head_sum[p][DATA_W]) begin
            res_code[p] = 2'd1;
            res_data[p] = head_sum[p][DATA_W-1:0];
          end
        end
        CMD_SUB: begin
          want_arith[p] = (count[p] != '0);
          if (head_op2[p] <= head_op1[p]) begin
            res_code[p] = 2'd1;
            res_data[p] = head_op1[p] - head_op2[p];
          end
        end
        CMD_LSH: begin
          want_shift[p] = (count[p] != '0);
          res_code[p]   = 2'd1;
          res_data[p]   = head_op1[p] << head_op2[p][SW-1:0];
        end
        CMD_RSH: begin
          want_shift[p] = (count[p] != '0);
          res_code[p]   = 2'd1;
          res_data[p]   = head_op1[p] >> head_op2[p][SW-1:0];
        end
        default: head_invalid[p] = (count[p] != '0);
      endcase
    end
  end

  assign grant_arith = rr_pick(want_arith, rr_arith);
  assign grant_shift = rr_pick(want_shift, rr_shift);
  assign pop         = grant_arith | grant_shift | head_invalid;

  // A full FIFO still accepts when its head leaves in the same cycle.
  always_comb begin
    push    = '0;
    push_ok = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      push[p]    = (cap_state[p] == S_OP2);
      push_ok[p] = push[p] && ((count[p] < CW'(DEPTH)) || pop[p]);
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        cap_state[p] <= S_IDLE;
        cap_cmd[p]   <= '0;
        cap_op1[p]   <= '0;
        rd_ptr[p]    <= '0;
        wr_ptr[p]    <= '0;
        count[p]     <= '0;
      end
      err_pend <= '0;
      rr_arith <= '0;
      rr_shift <= '0;
      out_resp <= '0;
      out_data <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        case (cap_state[p])
          S_IDLE: begin
            if (req_cmd_in[p*4 +: 4] != 4'd0) begin
              cap_state[p] <= S_OP2;
              cap_cmd[p]   <= req_cmd_in[p*4 +: 4];
              cap_op1[p]   <= req_data_in[p*DATA_W +: DATA_W];
            end
          end
          default: cap_state[p] <= S_IDLE;
        endcase

        if (push_ok[p]) begin
          q_cmd[p][wr_ptr[p]] <= cap_cmd[p];
          q_op1[p][wr_ptr[p]] <= cap_op1[p];
          q_op2[p][wr_ptr[p]] <= req_data_in[p*DATA_W +: DATA_W];
          wr_ptr[p] <= (wr_ptr[p] == PW'(DEPTH-1)) ? '0 : wr_ptr[p] + 1'b1;
        end
        if (pop[p])
          rd_ptr[p] <= (rd_ptr[p] == PW'(DEPTH-1)) ? '0 : rd_ptr[p] + 1'b1;
        if (push_ok[p] && !pop[p])
          count[p] <= count[p] + 1'b1;
        else if (!push_ok[p] && pop[p])
          count[p] <= count[p] - 1'b1;

        // Normal responses take priority; a pending drop error waits for a free slot.
        if (pop[p]) begin
          out_resp[p*2 +: 2]           <= res_code[p];
          out_data[p*DATA_W +: DATA_W] <= res_data[p];
        end else if (err_pend[p]) begin
          out_resp[p*2 +: 2]           <= 2'd3;
          out_data[p*DATA_W +: DATA_W] <= '0;
        end else begin
          out_resp[p*2 +: 2]           <= 2'd0;
          out_data[p*DATA_W +: DATA_W] <= '0;
        end
        err_pend[p] <= (err_pend[p] & pop[p]) | (push[p] & ~push_ok[p]);

        if (grant_arith[p])
          rr_arith <= (p == NUM_PORTS - 1) ? '0 : IW'(p + 1);
        if (grant_shift[p])
          rr_shift <= (p == NUM_PORTS - 1) ? '0 : IW'(p + 1);
      end
    end
  end

endmodule

// File: tb/tb_calcn_engine.sv
// Self-checking bench for calcn_engine: directed vector table, multi-cycle
// arbitration/overflow/reset sequences, and randomized traffic against a model.
module tb_calcn_engine;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int OW = NP * DW;

  logic            c_clk = 1'b0;
  logic            reset;
  logic [NP*4-1:0] cmd_v, cmd1_v;
  logic [OW-1:0]   dat_v, dat1_v;
  logic [NP*2-1:0] resp, resp1;
  logic [OW-1:0]   odata, odata1;

  calcn_engine #(.NUM_PORTS(NP), .DATA_W(DW), .DEPTH(2)) dut (
    .c_clk(c_clk), .reset(reset), .req_cmd_in(cmd_v), .req_data_in(dat_v),
    .out_resp(resp), .out_data(odata));

  calcn_engine #(.NUM_PORTS(NP), .DATA_W(DW), .DEPTH(1)) dut1 (
    .c_clk(c_clk), .reset(reset), .req_cmd_in(cmd1_v), .req_data_in(dat1_v),
    .out_resp(resp1), .out_data(odata1));

  always #5 c_clk = ~c_clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  logic [NP*2-1:0] er;
  logic [OW-1:0]   ed;
  logic [NP*2-1:0] mr [int];
  logic [OW-1:0]   md [int];

  typedef struct {
    int         port;
    logic [3:0] cmd;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [1:0] r;
    logic [DW-1:0] d;
  } vec_t;
  vec_t vt [10];

  task automatic step();
    @(posedge c_clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  task automatic chk_out(input string name);
    chk({name, ".resp"}, OW'(resp), OW'(er));
    chk({name, ".data"}, odata, ed);
  endtask

  task automatic chk_out1(input string name);
    chk({name, ".resp"}, OW'(resp1), OW'(er));
    chk({name, ".data"}, odata1, ed);
  endtask

  task automatic setp(input int p, input logic [3:0] c, input logic [DW-1:0] d);
    cmd_v[p*4 +: 4] = c;
    dat_v[p*DW +: DW] = d;
  endtask

  task automatic set1(input int p, input logic [3:0] c, input logic [DW-1:0] d);
    cmd1_v[p*4 +: 4] = c;
    dat1_v[p*DW +: DW] = d;
  endtask

  task automatic clear_all();
    cmd_v = '0; dat_v = '0;
  endtask

  task automatic clear1();
    cmd1_v = '0; dat1_v = '0;
  endtask

  task automatic exp_none();
    er = '0; ed = '0;
  endtask

  task automatic expp(input int p, input logic [1:0] r, input logic [DW-1:0] d);
    er[p*2 +: 2] = r;
    ed[p*DW +: DW] = d;
  endtask

  // Reference arithmetic taken straight from the command definitions.
  function automatic void model(input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                output logic [1:0] r, output logic [DW-1:0] d);
    logic [63:0] s;
    r = 2'd2;
    d = '0;
    case (c)
      4'd1: begin
        s = 64'(a) + 64'(b);
        if (s < (64'd1 << DW)) begin r = 2'd1; d = DW'(s); end
      end
      4'd2: if (a >= b) begin r = 2'd1; d = a - b; end
      4'd5: begin r = 2'd1; d = a << (b % DW); end
      4'd6: begin r = 2'd1; d = a >> (b % DW); end
      default: ;
    endcase
  endfunction

  task automatic record(input int at, input int p, input logic [1:0] r, input logic [DW-1:0] d);
    logic [NP*2-1:0] tr;
    logic [OW-1:0]   td;
    tr = mr.exists(at) ? mr[at] : '0;
    td = md.exists(at) ? md[at] : '0;
    tr[p*2 +: 2] = r;
    td[p*DW +: DW] = d;
    mr[at] = tr;
    md[at] = td;
  endtask

  task automatic chk_rand();
    er = mr.exists(cyc) ? mr[cyc] : '0;
    ed = md.exists(cyc) ? md[cyc] : '0;
    chk_out("random");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    int p, sel, v;
    logic [3:0] c;
    logic [DW-1:0] a, b, d;
    logic [1:0] r;

    vt[0] = '{0, 4'd1,  32'd5,          32'd7,  2'd1, 32'd12};
    vt[1] = '{1, 4'd1,  32'hFFFF_FFFF,  32'd1,  2'd2, 32'd0};
    vt[2] = '{2, 4'd2,  32'd3,          32'd4,  2'd2, 32'd0};
    vt[3] = '{3, 4'd4,  32'd9,          32'd9,  2'd2, 32'd0};
    vt[4] = '{0, 4'd5,  32'h1,          32'h21, 2'd1, 32'h2};
    vt[5] = '{1, 4'd6,  32'h8000_0000,  32'd31, 2'd1, 32'h1};
    vt[6] = '{2, 4'd2,  32'd10,         32'd10, 2'd1, 32'd0};
    vt[7] = '{3, 4'd1,  32'hFFFF_FFFE,  32'd1,  2'd1, 32'hFFFF_FFFF};
    vt[8] = '{0, 4'd15, 32'd1,          32'd2,  2'd2, 32'd0};
    vt[9] = '{1, 4'd5,  32'hFFFF_FFFF,  32'd31, 2'd1, 32'h8000_0000};

    clear_all(); clear1();
    reset = 1'b1;
    setp(0, 4'd1, 32'h1234);
    set1(0, 4'd1, 32'h55);
    step(); step();
    exp_none(); chk_out("reset_state"); chk_out1("reset_state_d1");
    reset = 1'b0;
    clear_all(); clear1();
    for (int i = 0; i < 3; i++) begin
      step(); exp_none(); chk_out("cmd_during_reset_ignored");
    end

    for (int i = 0; i < 10; i++) begin
      setp(vt[i].port, vt[i].cmd, vt[i].a);
      step();
      setp(vt[i].port, 4'hF, vt[i].b);
      step();
      exp_none(); chk_out("vec_not_early");
      clear_all();
      step();
      exp_none(); expp(vt[i].port, vt[i].r, vt[i].d); chk_out("vec_result");
      step();
      exp_none(); chk_out("vec_one_cycle");
    end

    setp(1, 4'd1, 32'd20); setp(3, 4'd5, 32'd3);
    step();
    setp(1, 4'd0, 32'd22); setp(3, 4'd0, 32'd4);
    step();
    clear_all(); setp(1, 4'd5, 32'h10);
    step();
    exp_none(); expp(1, 2'd1, 32'd42); expp(3, 2'd1, 32'd48); chk_out("units_parallel");
    setp(1, 4'd0, 32'd2);
    step();
    exp_none(); chk_out("units_gap");
    clear_all();
    step();
    exp_none(); expp(1, 2'd1, 32'h40); chk_out("units_order");

    for (int q = 0; q < NP; q++) set1(q, 4'd1, 32'(q * 16));
    step();
    for (int q = 0; q < NP; q++) set1(q, 4'd0, 32'd1);
    step();
    clear1(); set1(1, 4'd1, 32'd50); set1(2, 4'd1, 32'd7);
    step();
    exp_none(); expp(0, 2'd1, 32'd1); chk_out1("d1_grant_p0");
    set1(1, 4'd0, 32'd5); set1(2, 4'd0, 32'd7);
    step();
    exp_none(); expp(1, 2'd1, 32'd17); chk_out1("d1_grant_p1");
    clear1(); set1(2, 4'd1, 32'd100);
    step();
    exp_none(); expp(2, 2'd1, 32'd33); chk_out1("d1_grant_p2");
    set1(2, 4'd0, 32'd23);
    step();
    exp_none(); expp(3, 2'd1, 32'd49); expp(2, 2'd3, 32'd0); chk_out1("d1_overflow_err");
    clear1();
    step();
    exp_none(); expp(1, 2'd1, 32'd55); chk_out1("d1_push_on_pop");
    step();
    exp_none(); expp(2, 2'd1, 32'd123); chk_out1("d1_after_err");
    step();
    exp_none(); chk_out1("d1_quiet");

    for (int q = 0; q < 3; q++) setp(q, 4'd1, 32'(10 + q));
    step();
    for (int q = 0; q < 3; q++) setp(q, 4'd0, 32'd5);
    step();
    reset = 1'b1;
    clear_all(); setp(3, 4'd2, 32'd9);
    step();
    exp_none(); chk_out("reset_mid_queue");
    reset = 1'b0;
    clear_all();
    for (int i = 0; i < 4; i++) begin
      step(); exp_none(); chk_out("no_resp_after_reset");
    end
    setp(0, 4'd1, 32'd1);
    step();
    setp(0, 4'd0, 32'd1);
    step();
    clear_all();
    step();
    exp_none(); expp(0, 2'd1, 32'd2); chk_out("fresh_add");

    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int bu = 0; bu < 2; bu++) begin
      for (int q = 0; q < NP; q++) setp(q, 4'd1, 32'(q * 16 + bu));
      step();
      for (int q = 0; q < NP; q++) setp(q, 4'd0, 32'd100);
      step();
      clear_all();
      for (int k = 0; k < NP; k++) begin
        step();
        exp_none(); expp(k, 2'd1, 32'(k * 16 + bu + 100)); chk_out("burst_rotation");
      end
      step();
      exp_none(); chk_out("burst_quiet");
    end

    for (int i = 0; i < 80; i++) begin
      p = $urandom_range(0, NP - 1);
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1: c = 4'd1;
        2, 3: c = 4'd2;
        4, 5: c = 4'd5;
        6, 7: c = 4'd6;
        default: begin
          v = $urandom_range(0, 10);
          c = (v == 0) ? 4'd3 : (v == 1) ? 4'd4 : 4'(v + 5);
        end
      endcase
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a = $urandom_range(0, 1000);
      b = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 70);
      model(c, a, b, r, d);
      record(cyc + 3, p, r, d);
      clear_all(); setp(p, c, a);
      step(); chk_rand();
      setp(p, 4'($urandom_range(1, 15)), b);
      step(); chk_rand();
      clear_all();
      if ($urandom_range(0, 2) == 0) begin
        step(); chk_rand();
      end
    end
    clear_all();
    for (int i = 0; i < 3; i++) begin
      step(); chk_rand();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/calcn_engine.md
CALCN_ENGINE -- requirements
Module: calcn_engine

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of independent request/response channels, range 1..8.
REQ-002 SHALL have parameter DATA_W, default 32: operand and result width, a power of 2, range 8..64.
REQ-003 SHALL have parameter DEPTH, default 2: per-port request FIFO entries, a power of 2, range 1..8.
REQ-004 SHALL have port c_clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, width 1: synchronous, active-high reset.
REQ-006 SHALL have port req_cmd_in, input, width NUM_PORTS*4: per-port command; port p uses bits p*4..p*4+3.
REQ-007 SHALL have port req_data_in, input, width NUM_PORTS*DATA_W: per-port operand; port p uses bits p*DATA_W..p*DATA_W+DATA_W-1.
REQ-008 SHALL have port out_resp, output, width NUM_PORTS*2: per-port response code, 0 none, 1 success, 2 overflow/underflow/invalid, 3 internal error.
REQ-009 SHALL have port out_data, output, width NUM_PORTS*DATA_W: per-port result, valid only in the cycle its out_resp is nonzero.

Function
REQ-010 Commands SHALL be 0 NOP, 1 ADD, 2 SUB, 5 LSH and 6 RSH; all other codes SHALL be invalid.
REQ-011 Per-port capture FSM: IDLE; nonzero cmd -> latch cmd and operand1, go OP2; OP2 -> latch operand2, ignore req_cmd_in, go IDLE.
REQ-012 At the OP2 edge, the entry {cmd, op1, op2} SHALL be pushed into that port's FIFO.
REQ-013 A push SHALL be accepted if count<DEPTH or the head is popped in the same cycle.
REQ-014 A rejected push SHALL be dropped and SHALL set a per-port error-pending flag.
REQ-015 Two shared units SHALL exist: arith (ADD/SUB) and shift (LSH/RSH); each grants at most one port per cycle.
REQ-016 Each unit SHALL arbitrate round-robin among ports whose FIFO head is of its type; the pointer advances to the port after the granted one.
REQ-017 A granted head SHALL pop in the grant cycle; its response SHALL appear on out_resp/out_data exactly one cycle later and last one cycle.
REQ-018 An invalid-command head SHALL pop without arbitration and respond 2 with data 0 in the next cycle.
REQ-019 Minimum latency: cmd in cycle T, op2 in T+1, response in T+3.
REQ-020 Responses per port SHALL be in request order.
REQ-021 ADD: result = (op1+op2) mod 2^DATA_W; a carry out SHALL give response 2 with data 0.
REQ-022 SUB: result = op1-op2; if op2>op1 the response SHALL be 2 with data 0.
REQ-023 Shifts: amount = low log2(DATA_W) bits of op2; zero-fill; LSH = op1<<amt, RSH = op1>>amt; response 1.
REQ-024 A pending error flag SHALL emit response 3 with data 0 in the first cycle with no normal response on that port, then clear.
REQ-025 Idle outputs SHALL be driven 0, never floating.

Reset
REQ-026 While reset is high at a rising edge, all FIFOs, capture FSMs, error flags and arbiters SHALL clear; all outputs SHALL be 0 the next cycle.
REQ-027 Round-robin pointers SHALL reset to port 0.
REQ-028 Requests captured, queued or granted before reset SHALL never produce a response after reset.
REQ-029 A command presented in the same cycle as reset SHALL be ignored.

Verification
REQ-030 Port 0 ADD 5+7 -> out_resp[0]=1, data 12 at T+3; all other ports respond 0.
REQ-031 ADD 0xFFFFFFFF+1 -> response 2, data 0. SUB 3-4 -> response 2, data 0. Command 4 -> response 2, data 0.
REQ-032 LSH 0x1 by 0x21 (amt 1) -> response 1, data 0x2. RSH 0x80000000 by 31 -> response 1, data 0x1.
REQ-033 All 4 ports issue ADD in the same cycle -> responses on ports 0,1,2,3 at T+3..T+6; next simultaneous burst repeats the rotation starting at port 0.
REQ-034 Port 1: ADD and LSH back-to-back -> both served by separate units; responses in issue order; shift-unit arbitration is independent.
REQ-035 DEPTH=1: hold the arith unit busy on other ports, then overfill port 2 -> one response 3 with data 0, with all accepted requests still answered.
REQ-036 Reset asserted while 3 requests are queued -> no responses after reset; outputs 0; a fresh ADD 1+1 answers 2 at T+3.
